// File: rtl/exp_golomb_enc_lut.sv
// exp_golomb_enc_lut
//   Unsigned Exp-Golomb ue(v) encoder and bitstream packer. The encoder turns
//   each 9-bit syntax value into a variable-length code. Those codes are
//   interleaved with raw bytes in the order they arrive, MSB first, and the
//   resulting stream is emitted as 16-bit words.
//
//   Ports
//     clk            : clock, rising edge
//     rst            : asynchronous reset, active low
//     axiid/axiiv    : value to encode and its strobe (one code per cycle)
//     dout/byte_available : raw byte and its strobe (one byte per cycle)
//     ready          : downstream takes axiod this cycle
//     axiov/axiod    : word valid and the oldest 16 buffered bits
//                      (bit 15 is the earliest bit)
//
//   Buffered bits sit left-aligned in acc, and everything below cnt is kept
//   at zero. Because of that, each append can be a plain OR at a shifted
//   position.
module exp_golomb_enc_lut #(
  parameter int ACC_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  axiid,
  input  logic        axiiv,
  input  logic [7:0]  dout,
  input  logic        byte_available,
  input  logic        ready,
  output logic        axiov,
  output logic [15:0] axiod
);

  // One spare bit so that cnt + len never wraps when the fit test is made.
  localparam int CW = $clog2(ACC_W + 1) + 1;

  if (ACC_W < 16 + 19 + 8) begin : g_bad_w
    $error("ACC_W too small");
  end

  logic [ACC_W-1:0] acc, acc_n;
  logic [CW-1:0]    cnt, cnt_n, cnt_p, cnt_c, len_w;
  logic [9:0]       vp1;
  logic [3:0]       n;
  logic [4:0]       len;
  logic             pop, code_ok, byte_ok;

  // Code table. The code is v+1 written in exactly len bits, so the N
  // leading zeros fall out of the width alone. N is the index of the top
  // set bit of v+1.
  always_comb begin
    vp1 = {1'b0, axiid} + 10'd1;
    n   = '0;
    for (int i = 0; i < 10; i++)
      if (vp1[i]) n = 4'(i);
    len = {n, 1'b0} + 5'd1;
  end

  // The pop is applied first. The code then goes in behind the remaining
  // bits, and the byte goes in behind the code. Each item is accepted only
  // if it fits in full.
  always_comb begin
    pop     = axiov && ready;
    acc_n   = pop ? (acc << 16) : acc;
    cnt_p   = pop ? (cnt - CW'(16)) : cnt;
    len_w   = CW'(len);
    code_ok = axiiv && (cnt_p + len_w <= CW'(ACC_W));
    if (code_ok)
      acc_n = acc_n | (ACC_W'(vp1) << (CW'(ACC_W) - cnt_p - len_w));
    cnt_c   = code_ok ? (cnt_p + len_w) : cnt_p;
    byte_ok = byte_available && (cnt_c + CW'(8) <= CW'(ACC_W));
    if (byte_ok)
      acc_n = acc_n | (ACC_W'(dout) << (CW'(ACC_W) - cnt_c - CW'(8)));
    cnt_n   = byte_ok ? (cnt_c + CW'(8)) : cnt_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_n;
      cnt <= cnt_n;
    end
  end

  // Both outputs decode registers only.
  assign axiov = (cnt >= CW'(16));
  assign axiod = acc[ACC_W-1 -: 16];

endmodule

// File: tb/tb_exp_golomb_enc_lut.sv
module tb_exp_golomb_enc_lut;
  localparam int ACC_W = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  axiid = '0;
  logic        axiiv = 1'b0;
  logic [7:0]  dout = '0;
  logic        byte_available = 1'b0;
  logic        ready = 1'b0;
  logic        axiov;
  logic [15:0] axiod;

  exp_golomb_enc_lut #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv), .dout(dout),
    .byte_available(byte_available), .ready(ready), .axiov(axiov), .axiod(axiod)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit q[$];   // reference stream, front = oldest bit

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ue_len(input int v);
    int k = 0;
    while (((v + 1) >> (k + 1)) != 0) k++;
    return 2 * k + 1;
  endfunction

  task automatic push_bits(input int val, input int len);
    for (int i = len - 1; i >= 0; i--) q.push_back(bit'((val >> i) & 1));
  endtask

  // One clock cycle. On entry the time is just after an edge. The task
  // checks the DUT against the queue model, drives the inputs, and then
  // advances past the next edge.
  task automatic cyc(input bit iv, input int id, input bit bv, input int bd, input bit rdy);
    bit          exp_v;
    logic [15:0] w;
    int          c;
    axiiv = iv; axiid = 9'(id); byte_available = bv; dout = 8'(bd); ready = rdy;
    exp_v = (q.size() >= 16);
    chk("mdl_vld", axiov, exp_v);
    if (exp_v) begin
      for (int i = 0; i < 16; i++) w[15-i] = q[i];
      chk("mdl_word", axiod, w);
    end
    @(posedge clk);
    if (exp_v && rdy) repeat (16) void'(q.pop_front());
    c = q.size();
    if (iv && c + ue_len(id) <= ACC_W) begin
      push_bits(id + 1, ue_len(id));
      c = q.size();
    end
    if (bv && c + 8 <= ACC_W) push_bits(bd, 8);
    #1;
  endtask

  task automatic do_reset(input string tag);
    axiiv = 0; byte_available = 0; ready = 0;
    #3;
    rst = 1'b0;
    #1;
    chk({tag, "_vld"}, axiov, 1'b0);
    chk({tag, "_dat"}, axiod, 16'h0000);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst0_vld", axiov, 1'b0);
    chk("rst0_dat", axiod, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;

    // Packing: "1" "010" "011" "10000001" "1" = A703
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 2, 0, 0, 1);
    cyc(0, 0, 1, 'h81, 1);
    chk("pk_lt16", axiov, 1'b0);
    cyc(1, 0, 0, 0, 1);
    chk("pk_vld", axiov, 1'b1);
    chk("pk_word", axiod, 16'hA703);
    cyc(0, 0, 0, 0, 1);
    chk("pk_empty", axiov, 1'b0);
    cyc(0, 0, 1, 'hFF, 1);
    cyc(0, 0, 1, 'hFF, 1);
    chk("pk_rem", axiod, 16'hFFFF);
    cyc(0, 0, 0, 0, 1);
    chk("pk_rem_pop", axiov, 1'b0);

    // Same cycle: the code goes before the byte -> "110000001", then 5A -> C0AD
    cyc(1, 0, 1, 'h81, 0);
    chk("sc_lt16", axiov, 1'b0);
    cyc(0, 0, 1, 'h5A, 0);
    chk("sc_vld", axiov, 1'b1);
    chk("sc_word", axiod, 16'hC0AD);

    // Reset in the middle of the stream, then confirm no stale bits remain
    do_reset("rst1");
    cyc(0, 0, 1, 'hFF, 0);
    cyc(0, 0, 1, 'hFF, 0);
    chk("rst1_stale", axiod, 16'hFFFF);
    cyc(0, 0, 0, 0, 1);
    chk("rst1_pop", axiov, 1'b0);

    // Backpressure: 511 codes (19 bits) stop at 57 bits
    cyc(1, 511, 0, 0, 0);
    chk("bp_first", axiod, 16'h0040);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 511, 0, 0, 0);
      chk("bp_hold", axiod, 16'h0040);
    end
    cyc(0, 0, 0, 0, 1);
    chk("bp_w1", axiod, 16'h0008);
    cyc(0, 0, 0, 0, 1);
    chk("bp_w2", axiod, 16'h0001);
    cyc(0, 0, 0, 0, 1);
    chk("bp_left", axiov, 1'b0);
    do_reset("rst2");

    // Code rejected while the byte in the same cycle still fits (46 -> 54 bits)
    cyc(1, 511, 0, 0, 0);
    cyc(1, 511, 0, 0, 0);
    cyc(0, 0, 1, 'hFF, 0);
    cyc(1, 511, 1, 'hA5, 0);
    chk("dr_w0", axiod, 16'h0040);
    cyc(0, 0, 0, 0, 1);
    chk("dr_w1", axiod, 16'h0008);
    cyc(0, 0, 0, 0, 1);
    chk("dr_w2", axiod, 16'h03FE);
    cyc(0, 0, 0, 0, 1);
    chk("dr_left", axiov, 1'b0);
    do_reset("rst3");

    // Table sweep, checked through the queue model
    for (int v = 0; v < 512; v++) begin
      cyc(1, v, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
    end
    do_reset("rst4");

    // Pops and appends together, with random backpressure
    for (int i = 0; i < 600; i++)
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
          bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
          $urandom_range(0, 3) != 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
